// File: rtl/cart_if.sv
// cart_if: host-side download/CPU bus bundle for the cartridge slot.
interface cart_if #(
    parameter int BANK_BITS = 2,
    parameter int ADDR_W    = 16
);
    logic                  ioctl_download;
    logic                  ioctl_wr;
    logic [7:0]            ioctl_index;
    logic [ADDR_W-1:0]     ioctl_addr;
    logic [7:0]            ioctl_data;
    logic [13:0]           cpu_addr;
    logic                  cart_cs;
    logic                  bank_wr;
    logic [7:0]            cpu_dout;
    logic                  clk_Q;
    logic                  autostart;
    logic                  eject;
    logic [7:0]            cart_dout;
    logic                  cart_int;
    logic                  loaded;
    logic [14+BANK_BITS:0] img_size;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_data,
        output cpu_addr, cart_cs, bank_wr, cpu_dout, clk_Q, autostart, eject,
        input  cart_dout, cart_int, loaded, img_size
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_data,
        input  cpu_addr, cart_cs, bank_wr, cpu_dout, clk_Q, autostart, eject,
        output cart_dout, cart_int, loaded, img_size
    );
endinterface

// File: rtl/cart_slot.sv
// cart_slot: banked cartridge ROM loaded over ioctl, read through the $C000 window.
module cart_slot #(
    parameter int BANK_BITS  = 2,
    parameter int ADDR_W     = 16,
    parameter int CART_INDEX = 1,
    parameter int MIN_BYTES  = 257
) (
    input logic   clk,
    input logic   reset,
    cart_if.slave bus
);
    localparam int AW = 14 + BANK_BITS;
    localparam int SW = 15 + BANK_BITS;
    localparam logic [SW-1:0] CAP = SW'(2 ** AW);

    typedef enum logic [1:0] {EMPTY, LOADING, LOADED} state_t;

    state_t                state, state_n;
    logic [7:0]            mem [2 ** AW];
    logic                  dl_q, blk;
    logic [BANK_BITS-1:0]  bank;
    logic [SW-1:0]         size, size_w;
    logic [AW-1:0]         mask, mask_n, eff, sz_m1;
    logic [7:0]            dout;
    logic                  idx_ok, start, fall, in_range, upd, we;
    logic                  unused;

    assign unused   = ^bus.cpu_dout;
    assign idx_ok   = bus.ioctl_index == 8'(CART_INDEX);
    // blk suppresses a false rising edge when reset releases with download held high
    assign start    = bus.ioctl_download & ~dl_q & ~blk & idx_ok & (state != LOADING);
    assign fall     = ~bus.ioctl_download & dl_q;
    assign in_range = (bus.ioctl_addr >> AW) == '0;
    assign upd      = reset & ~bus.eject & (state == LOADING) & bus.ioctl_wr & idx_ok;
    assign we       = upd & in_range;
    assign size_w   = in_range ? {1'b0, bus.ioctl_addr[AW-1:0]} + SW'(1) : CAP;
    assign eff      = {bank, bus.cpu_addr} & mask;
    assign sz_m1    = AW'(size - SW'(1));

    always_comb begin
        mask_n = sz_m1;
        for (int i = 1; i < AW; i++) mask_n = mask_n | (sz_m1 >> i);
        mask_n = mask_n | AW'(13'h1FFF);
    end

    always_comb
        state_n = bus.eject ? EMPTY :
                  start ? LOADING :
                  (state == LOADING && fall) ? (size >= SW'(MIN_BYTES) ? LOADED : EMPTY) :
                  state;

    always_ff @(posedge clk)
        if (!reset) state <= EMPTY;
        else state <= state_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            dl_q <= 1'b0;
            blk  <= 1'b1;
            bank <= '0;
            size <= '0;
            mask <= AW'(13'h1FFF);
            dout <= 8'hFF;
        end else begin
            dl_q <= bus.ioctl_download;
            if (!bus.ioctl_download) blk <= 1'b0;
            bank <= (bus.eject | start) ? '0 : bus.bank_wr ? bus.cpu_dout[BANK_BITS-1:0] : bank;
            size <= start ? '0 : (upd && size_w > size) ? size_w : size;
            if (state == LOADING && state_n == LOADED) mask <= mask_n;
            dout <= (state != LOADED) ? 8'hFF : bus.cart_cs ? mem[eff] : dout;
        end
    end

    always_ff @(posedge clk)
        if (we) mem[bus.ioctl_addr[AW-1:0]] <= bus.ioctl_data;

    assign bus.loaded    = state == LOADED;
    assign bus.cart_int  = bus.clk_Q & bus.autostart & bus.loaded;
    assign bus.cart_dout = bus.loaded ? dout : 8'hFF;
    assign bus.img_size  = size;
endmodule

// File: doc/cart_slot.md
CART_SLOT -- requirements
Module: cart_slot

Interface
REQ-001 Parameter BANK_BITS, default 2, number of bank-select bits; capacity = 2^(14+BANK_BITS) bytes (16 KB per bank).
REQ-002 Parameter ADDR_W, default 16, ioctl address width; SHALL be at least 14+BANK_BITS.
REQ-003 Parameter CART_INDEX, default 1, ioctl_index value that selects cartridge download.
REQ-004 Parameter MIN_BYTES, default 257, minimum loaded image size accepted as a valid cartridge.
REQ-005 clk  in  1  system clock (42.954 MHz); all logic on its rising edge.
REQ-006 reset  in  1  synchronous reset, active-low.
REQ-007 ioctl_download  in  1  download in progress.
REQ-008 ioctl_wr  in  1  download byte strobe, one clk wide.
REQ-009 ioctl_index  in  8  download target selector.
REQ-010 ioctl_addr  in  ADDR_W  download byte address.
REQ-011 ioctl_data  in  8  download byte.
REQ-012 cpu_addr  in  14  CPU address within the $C000 cartridge window.
REQ-013 cart_cs  in  1  cartridge window selected (decoder output).
REQ-014 bank_wr  in  1  one-clk strobe writing the bank register.
REQ-015 cpu_dout  in  8  CPU write data; bits [BANK_BITS-1:0] carry the bank number.
REQ-016 clk_Q  in  1  CPU Q clock, used as the cartridge interrupt source.
REQ-017 autostart  in  1  enables the cartridge interrupt.
REQ-018 eject  in  1  one-clk eject request.
REQ-019 cart_dout  out  8  cartridge read data.
REQ-020 cart_int  out  1  cartridge interrupt to PIA CB1.
REQ-021 loaded  out  1  a valid image is present.
REQ-022 img_size  out  15+BANK_BITS  byte count of the current image.

Function
REQ-023 The FSM SHALL have three states: EMPTY, LOADING and LOADED.
REQ-024 EMPTY/LOADED -> LOADING SHALL occur on a 0->1 edge of ioctl_download while ioctl_index==CART_INDEX; on that edge img_size is cleared and bank is set to 0.
REQ-025 In LOADING, each ioctl_wr with index match SHALL write ioctl_data to storage[ioctl_addr[13+BANK_BITS:0]].
REQ-026 In LOADING, each write SHALL set img_size to max(img_size, ioctl_addr+1).
REQ-027 A download write with ioctl_addr >= capacity SHALL be discarded; img_size SHALL saturate at capacity.
REQ-028 On the 1->0 edge of ioctl_download in LOADING, the FSM SHALL go to LOADED if img_size >= MIN_BYTES, else to EMPTY.
REQ-029 Downloads with a non-matching index SHALL NOT change state, storage or img_size.
REQ-030 Reads: when cart_cs=1 in LOADED, cart_dout SHALL equal storage[eff] one clk later (registered, 1-cycle latency).
REQ-031 eff = {bank, cpu_addr} AND mask, where mask = (smallest power of two >= img_size, minimum 2^13) - 1; smaller images therefore mirror.
REQ-032 mask SHALL be computed once on entry to LOADED and held.
REQ-033 cart_dout SHALL be 8'hFF when not LOADED.
REQ-034 cart_dout SHALL hold its last value when cart_cs=0.
REQ-035 bank_wr SHALL load bank <= cpu_dout[BANK_BITS-1:0] in any state; the new bank applies to the next read cycle.
REQ-036 cart_int SHALL equal clk_Q & autostart & loaded (combinational) and SHALL be 0 otherwise.
REQ-037 loaded SHALL be 1 exactly in state LOADED.
REQ-038 eject SHALL force EMPTY next clk and clear bank; storage is not cleared.
REQ-039 eject SHALL take priority over a simultaneous download edge or write; a load then starts only on a later 0->1 edge of ioctl_download.
REQ-040 A bank_wr coinciding with the load-start edge SHALL be overridden by the clear to 0.

Reset
REQ-041 While reset=0 on a clk edge: state=EMPTY, bank=0, img_size=0, mask=2^13-1, cart_dout=8'hFF, edge-detect register=0; storage is retained.
REQ-042 Reset asserted mid-download SHALL abandon the load; after release, no LOADING entry occurs until a fresh 0->1 download edge.

Verification
REQ-043 Load 16384 bytes with data = addr[7:0], index 1 -> loaded=1, img_size=16384; read cpu_addr 0x0123 -> cart_dout=0x23 one clk after cart_cs.
REQ-044 Load 8192 bytes -> read cpu_addr 0x2005 returns the byte at 0x0005 (mirror); cart_int follows clk_Q when autostart=1 and is 0 when autostart=0.
REQ-045 Load 200 bytes -> state EMPTY, loaded=0, cart_dout=0xFF, cart_int=0.
REQ-046 Load 65536 bytes (BANK_BITS=2), bank_wr with cpu_dout=0x02, read 0x0000 -> byte at 0x8000; a write with ioctl_addr>=65536 is dropped and img_size stays 65536.
REQ-047 eject asserted in the same clk as a download 0->1 edge -> EMPTY, bank=0, no load; the next fresh download edge starts a load.
REQ-048 reset=0 during LOADING -> EMPTY, img_size=0; download held high after release -> stays EMPTY.
